// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: bridge FSM states, AXI response codes and fixed AXI tie-offs.
// The DRAIN state exists only when APB2AXI_TIMEOUT_EN is defined.
package apb2axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
`ifdef APB2AXI_TIMEOUT_EN
        , ST_DRAIN
`endif
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return (data_width == 64) ? 3'd3 : 3'd2;
    endfunction

    // EXOKAY is folded into success; only SLVERR/DECERR flag an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/apb2axi_wdog.sv
// apb2axi_wdog: response watchdog, armed at launch and cleared on completion.
// Only instantiated when APB2AXI_TIMEOUT_EN is defined.
module apb2axi_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;
    logic          active;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            active <= 1'b0;
            count  <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
        end else if (active && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = active && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb2axi_bridge.sv
// apb2axi_bridge: APB slave to single-beat AXI4 master, one transfer in flight.
// Define APB2AXI_TIMEOUT_EN to add the response watchdog and DRAIN state.
module apb2axi_bridge
    import apb2axi_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      slave_psel,
    input  logic                      slave_penable,
    input  logic                      slave_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] slave_paddr,
    input  logic [DATA_WIDTH-1:0]     slave_pwdata,
    output logic [DATA_WIDTH-1:0]     slave_prdata,
    output logic                      slave_pready,
    output logic                      slave_pslverr,
    output logic [AXI_ADDR_WIDTH-1:0] master_aw_addr,
    output logic                      master_aw_valid,
    input  logic                      master_aw_ready,
    output logic [DATA_WIDTH-1:0]     master_w_data,
    output logic [DATA_WIDTH/8-1:0]   master_w_strb,
    output logic                      master_w_valid,
    input  logic                      master_w_ready,
    input  logic [1:0]                master_b_resp,
    input  logic                      master_b_valid,
    output logic                      master_b_ready,
    output logic [AXI_ADDR_WIDTH-1:0] master_ar_addr,
    output logic                      master_ar_valid,
    input  logic                      master_ar_ready,
    input  logic [DATA_WIDTH-1:0]     master_r_data,
    input  logic [1:0]                master_r_resp,
    input  logic                      master_r_valid,
    output logic                      master_r_ready
);

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ADDR_WIDTH-1:0] paddr_ext;
    logic                      setup;

    if (AXI_ADDR_WIDTH > APB_ADDR_WIDTH) begin : g_zext
        assign paddr_ext = {{(AXI_ADDR_WIDTH - APB_ADDR_WIDTH){1'b0}}, slave_paddr};
    end else begin : g_trunc
        assign paddr_ext = slave_paddr[AXI_ADDR_WIDTH-1:0];
    end

    assign setup          = slave_psel && !slave_penable;
    assign master_aw_addr = addr_q;
    assign master_ar_addr = addr_q;
    assign master_w_strb  = {(DATA_WIDTH/8){master_w_valid}};

`ifdef APB2AXI_TIMEOUT_EN
    logic expired;
    logic timed_out;
    logic is_write;

    apb2axi_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   ((state == ST_IDLE) && setup),
        .clear   (state == ST_DONE),
        .expired (expired)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            addr_q          <= '0;
            master_w_data   <= '0;
            slave_prdata    <= '0;
            slave_pready    <= 1'b0;
            slave_pslverr   <= 1'b0;
            master_aw_valid <= 1'b0;
            master_w_valid  <= 1'b0;
            master_b_ready  <= 1'b0;
            master_ar_valid <= 1'b0;
            master_r_ready  <= 1'b0;
`ifdef APB2AXI_TIMEOUT_EN
            timed_out       <= 1'b0;
            is_write        <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (setup) begin
                        addr_q        <= paddr_ext;
                        master_w_data <= slave_pwdata;
`ifdef APB2AXI_TIMEOUT_EN
                        is_write      <= slave_pwrite;
`endif
                        if (slave_pwrite) begin
                            master_aw_valid <= 1'b1;
                            master_w_valid  <= 1'b1;
                            state           <= ST_WADDR;
                        end else begin
                            master_ar_valid <= 1'b1;
                            state           <= ST_RADDR;
                        end
                    end
                end
                // AW and W retire independently; leave once neither is pending.
                ST_WADDR: begin
                    if (master_aw_ready) master_aw_valid <= 1'b0;
                    if (master_w_ready)  master_w_valid  <= 1'b0;
                    if ((!master_aw_valid || master_aw_ready) &&
                        (!master_w_valid  || master_w_ready)) begin
                        master_b_ready <= 1'b1;
                        state          <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (master_b_valid) begin
                        master_b_ready <= 1'b0;
                        slave_pready   <= 1'b1;
                        slave_pslverr  <= resp_is_err(master_b_resp);
                        state          <= ST_DONE;
                    end
`ifdef APB2AXI_TIMEOUT_EN
                    else if (expired) begin
                        master_b_ready <= 1'b0;
                        slave_pready   <= 1'b1;
                        slave_pslverr  <= 1'b1;
                        timed_out      <= 1'b1;
                        state          <= ST_DONE;
                    end
`endif
                end
                ST_RADDR: begin
                    if (master_ar_ready) begin
                        master_ar_valid <= 1'b0;
                        master_r_ready  <= 1'b1;
                        state           <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (master_r_valid) begin
                        master_r_ready <= 1'b0;
                        slave_prdata   <= master_r_data;
                        slave_pready   <= 1'b1;
                        slave_pslverr  <= resp_is_err(master_r_resp);
                        state          <= ST_DONE;
                    end
`ifdef APB2AXI_TIMEOUT_EN
                    else if (expired) begin
                        master_r_ready <= 1'b0;
                        slave_prdata   <= '0;
                        slave_pready   <= 1'b1;
                        slave_pslverr  <= 1'b1;
                        timed_out      <= 1'b1;
                        state          <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    slave_pready  <= 1'b0;
                    slave_pslverr <= 1'b0;
`ifdef APB2AXI_TIMEOUT_EN
                    if (timed_out) begin
                        master_b_ready <= is_write;
                        master_r_ready <= !is_write;
                        state          <= ST_DRAIN;
                    end else begin
                        state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef APB2AXI_TIMEOUT_EN
                // Swallow the late response so the slave is not left hanging.
                ST_DRAIN: begin
                    if ((is_write && master_b_valid) ||
                        (!is_write && master_r_valid)) begin
                        master_b_ready <= 1'b0;
                        master_r_ready <= 1'b0;
                        timed_out      <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb2axi_bridge.md
Name: apb2axi_bridge

Overview:
- APB slave to single-beat AXI4 master bridge. It is the reverse direction of the existing AXI-to-APB path.
- Lets an APB-side initiator (debug/DMA config port on the peripheral bus) reach the AXI interconnect.
- One outstanding transfer; each APB access becomes exactly one AXI read or write beat.
- AW/W/B/AR/R ports are flattened master_* signals; the wrapper ties off AXI id=0, len=0, burst=INCR, size=log2(DATA_WIDTH/8), lock/cache/qos/region/user=0.

Parameters:
APB_ADDR_WIDTH  32  APB address width
AXI_ADDR_WIDTH  32  AXI address width; paddr zero-extended or truncated to fit
DATA_WIDTH  32  shared APB/AXI data width; only 32 and 64 legal
TIMEOUT_CYCLES  255  watchdog limit, used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
slave_psel  in  1  APB select
slave_penable  in  1  APB enable
slave_pwrite  in  1  APB direction
slave_paddr  in  APB_ADDR_WIDTH  APB address
slave_pwdata  in  DATA_WIDTH  APB write data
slave_prdata  out  DATA_WIDTH  APB read data
slave_pready  out  1  APB ready
slave_pslverr  out  1  APB error
master_aw_addr  out  AXI_ADDR_WIDTH  write address
master_aw_valid  out  1  write address valid
master_aw_ready  in  1  write address ready
master_w_data  out  DATA_WIDTH  write data
master_w_strb  out  DATA_WIDTH/8  byte strobes, all ones
master_w_valid  out  1  write data valid
master_w_ready  in  1  write data ready
master_b_resp  in  2  write response
master_b_valid  in  1  write response valid
master_b_ready  out  1  write response ready
master_ar_addr  out  AXI_ADDR_WIDTH  read address
master_ar_valid  out  1  read address valid
master_ar_ready  in  1  read address ready
master_r_data  in  DATA_WIDTH  read data
master_r_resp  in  2  read response
master_r_valid  in  1  read data valid
master_r_ready  out  1  read data ready

Behaviour:
- Reset: all outputs 0, state IDLE.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - psel & !penable (setup phase) latches paddr/pwdata.
  - Next state is WADDR if pwrite, else RADDR.
  - aw_valid & w_valid, or ar_valid, rise registered on the next edge.
- WADDR:
  - aw_valid held until AW handshake; w_valid held until W handshake.
  - The two handshakes are independent and may occur in either order or the same cycle.
  - Each valid drops the cycle after its own handshake.
  - Move to WRESP once both have completed.
- WRESP: b_ready=1; on b_valid, capture resp and go to DONE.
- RADDR: ar_valid held until ar_ready, then go to RDATA.
- RDATA: r_ready=1; on r_valid, capture r_data into prdata and resp, then go to DONE.
- DONE:
  - pready=1 for exactly one cycle; pslverr = resp[1] (SLVERR/DECERR).
  - EXOKAY is treated as OKAY.
  - Return to IDLE.
- prdata holds its last read value; write accesses leave it unchanged.
- Minimum APB transfer with zero-wait AXI is 4 cycles:
  - setup T0; AW/W valid T1; B accepted T2; pready T3.
- pready is held low in every state except DONE.
- A new setup phase is accepted only in IDLE.
- psel withdrawn mid-transfer (protocol violation): AXI transfer still completes and the DONE pulse still occurs.
- Reset mid-operation: next edge forces IDLE and all valid/ready low. The subsystem resets together, so no outstanding AXI completion is attempted.

Optional Feature:
- Macro: APB2AXI_TIMEOUT_EN.
- Defined:
  - A counter starts at launch.
  - If no B/R response arrives within TIMEOUT_CYCLES, go to DONE with pslverr=1 and prdata=0.
  - Then enter DRAIN, holding b_ready/r_ready=1 until the late response arrives and is discarded.
  - New APB setup phases are not accepted during DRAIN.
- Undefined: no counter and no DRAIN state; the bridge waits indefinitely.

Decomposition:
- Package apb2axi_pkg holds:
  - the state enum;
  - AXI resp constants RESP_OKAY/EXOKAY/SLVERR/DECERR (2'b00..2'b11);
  - fixed tie-off constants (len, burst).
- Sub-module apb2axi_wdog holds the timeout counter (start, clear, expired); it is instantiated only under the macro.

Test Plan:
- Write 0xDEADBEEF to 0x1A10_0004 with AXI readies always high -> aw_addr=0x1A100004, w_data=0xDEADBEEF, w_strb=0xF at T1; b OKAY at T2; pready=1 only at T3, pslverr=0.
- Read 0x1A10_2000; ar_ready low for 5 cycles, then r_data=0x12345678 OKAY -> ar_valid held 6 cycles; prdata=0x12345678 with a single pready pulse.
- aw_ready at T1, w_ready at T4 -> aw_valid low from T2, w_valid held to T4; b_ready only from T5.
- b_resp=SLVERR -> pslverr=1. Read with r_resp=DECERR, r_data=0xBAD0BAD0 -> pslverr=1, prdata=0xBAD0BAD0.
- rst_i pulsed in WRESP -> all valid/ready/pready low next cycle; a following write completes normally.
- Macro on, TIMEOUT_CYCLES=16, b_valid withheld -> pready+pslverr 16 cycles after launch. A late b_valid is consumed silently; a setup phase during DRAIN waits until DRAIN exits.
